bsearch_engine: RTL and testbench
=================================

# bsearch_engine

- Parametrised binary-search engine over a sorted synchronous RAM of `2**ADDR_W` entries of `DATA_W` bits.
- Owns its own bound/midpoint datapath and issues RAM reads with configurable read latency.
- Terminates with either hit plus index or an explicit miss; a search can never hang.
- Sits between the top-level control (switches/keys) and the on-chip RAM holding an ascending-sorted array.

## Interface
Parameters:
- `DATA_W`, 8, width of stored words and of the search target
- `ADDR_W`, 5, RAM address width; depth = `2**ADDR_W`
- `RD_LAT`, 1, RAM read latency in cycles; legal values 1..4

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low; low forces every register to its reset value immediately
- `start`  in  1  level request; a search launches on a rising-edge-free sample of `start`=1 in IDLE
- `target`  in  `DATA_W`  value searched for; sampled only in the launch cycle
- `mem_addr`  out  `ADDR_W`  RAM read address, registered
- `mem_rdata`  in  `DATA_W`  RAM read data, valid `RD_LAT` cycles after `mem_addr` changes
- `busy`  out  1  high from launch until DONE is entered
- `done`  out  1  high while in DONE
- `found`  out  1  in DONE: 1 = hit, 0 = miss; 0 outside DONE
- `found_addr`  out  `ADDR_W`  index of hit; 0 on miss and outside DONE
- `steps`  out  `ADDR_W+1`  probe count of the last search (only with `BSEARCH_STEPS_EN`)

## Operation
- States: IDLE, ISSUE, WAIT, COMPARE, DONE.
- IDLE: `low`=0, `high`=`2**ADDR_W-1` (both `ADDR_W+1` bits); on `start`=1 latch `target` → ISSUE.
- ISSUE: `mid` = (`low`+`high`)>>1 computed at `ADDR_W+1` bits (no overflow); `mem_addr` <= `mid[ADDR_W-1:0]`. → WAIT if `RD_LAT`>1, else → COMPARE.
- WAIT: counts `RD_LAT-1` cycles, `mem_addr` held stable → COMPARE.
- COMPARE (unsigned compare of `mem_rdata` with latched target):
  - equal → DONE, hit, `found_addr`=`mid`;
  - `mem_rdata` > target → `high`=`mid`-1;
  - `mem_rdata` < target → `low`=`mid`+1;
  - after an update, if `low` > `high` → DONE, miss; otherwise → ISSUE.
- `high`=`mid`-1 with `mid`=0 yields all-ones at `ADDR_W+1` bits; this must be detected as a miss, not wrap to a legal index. Compare treats `high`'s MSB as a sign/underflow flag (`low`>`high` iff underflow or numeric greater).
- DONE: outputs held; stays while `start`=1; `start`=0 → IDLE. Holding `start` high never re-launches.
- `target` changes after launch are ignored.
- Duplicate keys: any matching index is a legal hit.

## Timing
- Reset values: `mem_addr`=0, `busy`=0, `done`=0, `found`=0, `found_addr`=0, `steps`=0, state IDLE.
- Launch: `start` sampled at edge e0; `busy`=1 and ISSUE from e0.
- Per probe: `RD_LAT`+1 cycles (ISSUE, `RD_LAT-1` WAIT, COMPARE).
- Max probes: `ADDR_W`+1 (miss above the top entry). Worst-case start-to-`done` = (`ADDR_W`+1)·(`RD_LAT`+1) cycles.
- `done`, `found`, `found_addr` become valid the cycle after the deciding COMPARE, together with `busy`=0.
- Reset asserted mid-search: immediate return to IDLE with all outputs at reset values; no stale `done`.
- `start`=0 during a search does not abort it.

## Configuration
- `BSEARCH_STEPS_EN` defined:
  - `steps` port exists;
  - cleared at launch, incremented in each COMPARE, held in DONE and IDLE until the next launch.
- Undefined: no `steps` port and no counter; all other behaviour identical.

## Test plan
- `ADDR_W`=5, `RD_LAT`=1, mem[i]=2i; target 20 → `found`=1, `found_addr`=10, `steps`=5, `done` after ≤12 cycles.
- Same memory, target 21 → `found`=0, `found_addr`=0, `done`=1, search terminates.
- Target 0 → hit at 0; target 255 → miss with no index wrap; target 62 → hit at 31. Repeat all three with `RD_LAT`=3 and check a probe period of 4 cycles.
- Hold `start`=1 through and after `done` → `done` stays 1 with no relaunch; drop `start` → IDLE next cycle and `done`=0.
- Pull `reset` low at cycle 3 of a search → all outputs 0 immediately. Release `reset` and launch target 20 → correct hit.
- Change `target` mid-search from 20 to 40 → result still `found_addr`=10.

Source files
------------

// File: rtl/bsearch_if.sv
// Search-request and RAM-read bundle for bsearch_engine. The engine uses the slave modport; the
// master side is the top-level control together with the RAM that returns mem_rdata.
interface bsearch_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [DATA_W-1:0] target;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic              found;
  logic [ADDR_W-1:0] found_addr;

  modport master (
    output start, target, mem_rdata,
    input  mem_addr, busy, done, found, found_addr
  );

  modport slave (
    input  start, target, mem_rdata,
    output mem_addr, busy, done, found, found_addr
  );
endinterface

// File: rtl/bsearch_engine.sv
// Binary-search engine over an ascending-sorted synchronous RAM with RD_LAT-cycle read latency.
// Optional probe counter on the steps port is built only when BSEARCH_STEPS_EN is defined.
module bsearch_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  bsearch_if.slave         bus,
`ifdef BSEARCH_STEPS_EN
  output logic [ADDR_W:0]  steps,
`endif
  output logic [2:0]       dbg_state
);
  // Handshake: start is a level request. A search launches when start=1 is seen in IDLE, and busy
  // stays high until DONE. DONE holds done/found/found_addr for as long as start stays high, and
  // start=0 returns the engine to IDLE. Holding start high never launches a second search.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] TOP       = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] ONE       = 1;
  localparam logic [1:0]      WAIT_LAST = 2'(RD_LAT > 1 ? RD_LAT - 2 : 0);

  state_t            state;
  logic [ADDR_W:0]   low, high, mid;
  logic [DATA_W-1:0] target_q;
  logic [1:0]        wait_cnt;

  logic [ADDR_W:0]   sum, mid_calc, low_nx, high_nx;
  logic              hit, miss;

  assign dbg_state = state;

  // Bounds stay below 2**ADDR_W while probing, so their sum fits in ADDR_W+1 bits.
  always_comb begin
    sum      = low + high;
    mid_calc = sum >> 1;
  end

  // mid-1 at mid=0 sets the extra MSB of high; that bit marks an empty range and must end the search as a miss.
  always_comb begin
    low_nx  = low;
    high_nx = high;
    hit     = (bus.mem_rdata == target_q);
    if (bus.mem_rdata > target_q) high_nx = mid - ONE;
    else                          low_nx  = mid + ONE;
    miss    = high_nx[ADDR_W] || (low_nx > high_nx);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      low            <= '0;
      high           <= TOP;
      mid            <= '0;
      target_q       <= '0;
      wait_cnt       <= '0;
      bus.mem_addr   <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.found      <= 1'b0;
      bus.found_addr <= '0;
`ifdef BSEARCH_STEPS_EN
      steps          <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          low  <= '0;
          high <= TOP;
          if (bus.start) begin
            target_q <= bus.target;
            bus.busy <= 1'b1;
            state    <= S_ISSUE;
`ifdef BSEARCH_STEPS_EN
            steps    <= '0;
`endif
          end
        end
        S_ISSUE: begin
          mid          <= mid_calc;
          bus.mem_addr <= mid_calc[ADDR_W-1:0];
          wait_cnt     <= '0;
          state        <= (RD_LAT > 1) ? S_WAIT : S_COMPARE;
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= S_COMPARE;
          else                       wait_cnt <= wait_cnt + 2'd1;
        end
        S_COMPARE: begin
`ifdef BSEARCH_STEPS_EN
          steps <= steps + ONE;
`endif
          if (hit) begin
            bus.done       <= 1'b1;
            bus.found      <= 1'b1;
            bus.found_addr <= mid[ADDR_W-1:0];
            bus.busy       <= 1'b0;
            state          <= S_DONE;
          end else begin
            low  <= low_nx;
            high <= high_nx;
            if (miss) begin
              bus.done       <= 1'b1;
              bus.found      <= 1'b0;
              bus.found_addr <= '0;
              bus.busy       <= 1'b0;
              state          <= S_DONE;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          if (!bus.start) begin
            bus.done       <= 1'b0;
            bus.found      <= 1'b0;
            bus.found_addr <= '0;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bsearch_engine.sv
// Bench for bsearch_engine: two instances (read latency 1 and 3) share one sorted memory image.
module tb_bsearch_engine;
  localparam int DW      = 8;
  localparam int AW      = 5;
  localparam int DEPTH   = 1 << AW;
  localparam int LAT0    = 1;
  localparam int LAT1    = 3;
  localparam int TIMEOUT = 200;

  // Clock and reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bsearch_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  bsearch_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
  logic [2:0] dbg0, dbg1;
`ifdef BSEARCH_STEPS_EN
  logic [AW:0] steps0, steps1;
`endif

  bsearch_engine #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus0),
`ifdef BSEARCH_STEPS_EN
    .steps     (steps0),
`endif
    .dbg_state (dbg0)
  );

  bsearch_engine #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus1),
`ifdef BSEARCH_STEPS_EN
    .steps     (steps1),
`endif
    .dbg_state (dbg1)
  );

  // Memory model: latency 1 returns mem[addr] directly; latency 3 adds two register stages.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] pipe1, pipe2;
  logic          start_v  [2];
  logic [DW-1:0] target_v [2];

  assign bus0.mem_rdata = mem[bus0.mem_addr];
  always_ff @(posedge clk) begin
    pipe1 <= mem[bus1.mem_addr];
    pipe2 <= pipe1;
  end
  assign bus1.mem_rdata = pipe2;
  assign bus0.start  = start_v[0];
  assign bus0.target = target_v[0];
  assign bus1.start  = start_v[1];
  assign bus1.target = target_v[1];

  int n_checks = 0;
  int n_err    = 0;
  logic exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic get_busy(input int sel);
    return (sel != 0) ? bus1.busy : bus0.busy;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel != 0) ? bus1.done : bus0.done;
  endfunction
  function automatic logic get_found(input int sel);
    return (sel != 0) ? bus1.found : bus0.found;
  endfunction
  function automatic logic [AW-1:0] get_faddr(input int sel);
    return (sel != 0) ? bus1.found_addr : bus0.found_addr;
  endfunction

  // Driver tasks. Cycles are counted from the launch edge to the first sample showing done.
  task automatic do_search(input int sel, input logic [DW-1:0] t, input int chg_after,
                           input logic [DW-1:0] t2, output logic f,
                           output logic [AW-1:0] fa, output int cycles);
    @(negedge clk);
    start_v[sel]  = 1'b1;
    target_v[sel] = t;
    @(posedge clk); #1;
    check("busy_at_launch", 32'(get_busy(sel)), 32'd1);
    cycles = 0;
    while (!get_done(sel) && cycles < TIMEOUT) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == chg_after) target_v[sel] = t2;
    end
    check("done_reached", 32'(get_done(sel)), 32'd1);
    check("busy_in_done", 32'(get_busy(sel)), 32'd0);
    f  = get_found(sel);
    fa = get_faddr(sel);
  endtask

  task automatic release_start(input int sel);
    @(negedge clk);
    start_v[sel] = 1'b0;
    @(posedge clk); #1;
    check("done_after_release", 32'(get_done(sel)), 32'd0);
    check("found_after_release", 32'(get_found(sel)), 32'd0);
    check("faddr_after_release", 32'(get_faddr(sel)), 32'd0);
  endtask

  task automatic fill_even();
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(2 * i);
  endtask

  // Directed table for mem[i] = 2i; probe counts follow from halving the index range 0..31.
  logic [DW-1:0] d_tgt   [5] = '{8'd20, 8'd21, 8'd0, 8'd255, 8'd62};
  logic          d_found [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [AW-1:0] d_faddr [5] = '{5'd10, 5'd0, 5'd0, 5'd0, 5'd31};
  int            d_probe [5] = '{5, 5, 5, 6, 6};

  initial begin
    logic          f;
    logic [AW-1:0] fa;
    int            cyc;
    int            lat;
    logic          exp_f;
    logic [DW-1:0] t;
    int            run;

    start_v[0] = 1'b0; start_v[1] = 1'b0;
    target_v[0] = '0;  target_v[1] = '0;
    fill_even();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus0.busy), 32'd0);
    check("rst_done", 32'(bus0.done), 32'd0);
    check("rst_found", 32'(bus0.found), 32'd0);
    check("rst_faddr", 32'(bus0.found_addr), 32'd0);
    check("rst_mem_addr", 32'(bus0.mem_addr), 32'd0);
    check("rst_done_lat3", 32'(bus1.done), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed searches at both read latencies
    for (int sel = 0; sel < 2; sel++) begin
      lat = (sel != 0) ? LAT1 : LAT0;
      for (int k = 0; k < 5; k++) begin
        do_search(sel, d_tgt[k], -1, '0, f, fa, cyc);
        check($sformatf("found_t%0d_lat%0d", d_tgt[k], lat), 32'(f), 32'(d_found[k]));
        check($sformatf("faddr_t%0d_lat%0d", d_tgt[k], lat), 32'(fa), 32'(d_faddr[k]));
        check($sformatf("cycles_t%0d_lat%0d", d_tgt[k], lat), 32'(cyc), 32'(d_probe[k] * (lat + 1)));
`ifdef BSEARCH_STEPS_EN
        check($sformatf("steps_t%0d_lat%0d", d_tgt[k], lat),
              32'((sel != 0) ? steps1 : steps0), 32'(d_probe[k]));
`endif
        release_start(sel);
      end
    end

    // Hold start high through done: no relaunch, outputs held
    do_search(0, 8'd20, -1, '0, f, fa, cyc);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_done", 32'(bus0.done), 32'd1);
      check("hold_busy", 32'(bus0.busy), 32'd0);
      check("hold_faddr", 32'(bus0.found_addr), 32'd10);
    end
    release_start(0);

    // Target changes after launch are ignored
    do_search(0, 8'd20, 2, 8'd40, f, fa, cyc);
    check("chg_found", 32'(f), 32'd1);
    check("chg_faddr", 32'(fa), 32'd10);
    release_start(0);

    // Asynchronous reset mid-search
    @(negedge clk);
    start_v[0]  = 1'b1;
    target_v[0] = 8'd20;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(bus0.busy), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(bus0.busy), 32'd0);
    check("midrst_done", 32'(bus0.done), 32'd0);
    check("midrst_found", 32'(bus0.found), 32'd0);
    check("midrst_faddr", 32'(bus0.found_addr), 32'd0);
    check("midrst_mem_addr", 32'(bus0.mem_addr), 32'd0);
    start_v[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    do_search(0, 8'd20, -1, '0, f, fa, cyc);
    check("post_rst_found", 32'(f), 32'd1);
    check("post_rst_faddr", 32'(fa), 32'd10);
    release_start(0);

    // Random sorted memories (duplicates allowed) checked against a linear-scan reference
    for (int r = 0; r < 3; r++) begin
      run = $urandom_range(0, 3);
      for (int i = 0; i < DEPTH; i++) begin
        run += $urandom_range(0, 3);
        mem[i] = DW'(run);
      end
      for (int n = 0; n < 10; n++) begin
        for (int sel = 0; sel < 2; sel++) begin
          lat = (sel != 0) ? LAT1 : LAT0;
          t = ($urandom_range(0, 1) != 0) ? mem[$urandom_range(0, DEPTH - 1)]
                                          : DW'($urandom_range(0, 255));
          exp_f = 1'b0;
          for (int i = 0; i < DEPTH; i++) if (mem[i] == t) exp_f = 1'b1;
          exp_q.push_back(exp_f);
          do_search(sel, t, -1, '0, f, fa, cyc);
          exp_f = exp_q.pop_front();
          check("rnd_found", 32'(f), 32'(exp_f));
          if (exp_f) check("rnd_hit_value", 32'(mem[fa]), 32'(t));
          else       check("rnd_miss_faddr", 32'(fa), 32'd0);
          check("rnd_cycles_bound", 32'(cyc <= (AW + 1) * (lat + 1)), 32'd1);
          check("rnd_probe_period", 32'(cyc % (lat + 1)), 32'd0);
          release_start(sel);
        end
      end
    end

    // Final report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
